// File: rtl/multi_ch_pulse_sync.sv
// Multi-channel event importer: per-channel synchroniser chain, glitch filter,
// edge-selectable one-cycle pulses, sticky pending flags and saturating counters.
module multi_ch_pulse_sync #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                    fast_clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       async_in,
    input  logic [2*NUM_CH-1:0]     edge_mode,
    output logic [NUM_CH-1:0]       pulse_fast_out,
    output logic [NUM_CH-1:0]       level_out,
    output logic [NUM_CH-1:0]       pending,
    input  logic [NUM_CH-1:0]       clr_pending,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt,
    input  logic [NUM_CH-1:0]       cnt_clr,
    output logic [NUM_CH-1:0]       cnt_ovf
);
    localparam int               FLT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
    logic [FLT_W-1:0]  r_flt_cnt [NUM_CH];
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_level;
    logic [NUM_CH-1:0] r_pulse;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_ovf;

    logic [NUM_CH-1:0] w_sync_out;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_evt;

    // Acceptance and edge-mode qualification; mode is looked at only when a level is accepted
    always_comb begin
        w_sync_out = r_sync[SYNC_STAGES-1];
        w_accept   = '0;
        w_evt      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_accept[i] = (w_sync_out[i] != r_level[i]) && (r_flt_cnt[i] == FLT_LAST);
            case (edge_mode[2*i +: 2])
                2'b00:   w_evt[i] = w_accept[i] &  w_sync_out[i];
                2'b01:   w_evt[i] = w_accept[i] & ~w_sync_out[i];
                2'b10:   w_evt[i] = w_accept[i];
                default: w_evt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_flt_cnt[i] <= '0;
                r_cnt[i]     <= '0;
            end
            r_level <= '0;
            r_pulse <= '0;
            r_pend  <= '0;
            r_ovf   <= '0;
        end else begin
            r_sync[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_pulse <= w_evt;
            // A new event outranks a coincident clear
            r_pend  <= w_evt | (r_pend & ~clr_pending);
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sync_out[i] == r_level[i]) begin
                    r_flt_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_level[i]   <= w_sync_out[i];
                    r_flt_cnt[i] <= '0;
                end else begin
                    r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
                end

                // Clear coincident with an event leaves that event counted
                if (cnt_clr[i]) begin
                    r_cnt[i] <= w_evt[i] ? CNT_W'(1) : '0;
                    r_ovf[i] <= 1'b0;
                end else if (w_evt[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            evt_cnt[CNT_W*i +: CNT_W] = r_cnt[i];
        end
    end

    assign pulse_fast_out = r_pulse;
    assign level_out      = r_level;
    assign pending        = r_pend;
    assign cnt_ovf        = r_ovf;

endmodule

// File: tb/tb_multi_ch_pulse_sync.sv
// Directed bench: one default instance and one with FILTER_LEN=4, CNT_W=2,
// both driven from the same stimulus.
module tb_multi_ch_pulse_sync;
    logic       fast_clk;
    logic       rst_n;
    logic [3:0] async_in;
    logic [7:0] edge_mode;
    logic [3:0] clr_pending;
    logic [3:0] cnt_clr;

    logic [3:0]  a_pulse, a_level, a_pend, a_ovf;
    logic [31:0] a_evt;
    logic [3:0]  b_pulse, b_level, b_pend, b_ovf;
    logic [7:0]  b_evt;

    int checks = 0;
    int errors = 0;
    int a_pc [4];
    int b_pc [4];

    logic [1:0] exp_cnt [5];
    logic       exp_ovf [5];

    multi_ch_pulse_sync dut_a (
        .fast_clk(fast_clk), .rst_n(rst_n), .async_in(async_in), .edge_mode(edge_mode),
        .pulse_fast_out(a_pulse), .level_out(a_level), .pending(a_pend),
        .clr_pending(clr_pending), .evt_cnt(a_evt), .cnt_clr(cnt_clr), .cnt_ovf(a_ovf)
    );

    multi_ch_pulse_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(2)) dut_b (
        .fast_clk(fast_clk), .rst_n(rst_n), .async_in(async_in), .edge_mode(edge_mode),
        .pulse_fast_out(b_pulse), .level_out(b_level), .pending(b_pend),
        .clr_pending(clr_pending), .evt_cnt(b_evt), .cnt_clr(cnt_clr), .cnt_ovf(b_ovf)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge fast_clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                a_pc[c] += int'(a_pulse[c]);
                b_pc[c] += int'(b_pulse[c]);
            end
        end
    endtask

    task automatic clr_pc();
        for (int c = 0; c < 4; c++) begin
            a_pc[c] = 0;
            b_pc[c] = 0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        async_in    = '0;
        edge_mode   = '0;
        clr_pending = '0;
        cnt_clr     = '0;
        clr_pc();
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0; exp_ovf[2] = 1'b0; exp_ovf[3] = 1'b1; exp_ovf[4] = 1'b1;

        // Reset state
        tick(3);
        chk("rst_a_level", 32'(a_level), 32'h0);
        chk("rst_a_pulse", 32'(a_pulse), 32'h0);
        chk("rst_a_pend",  32'(a_pend),  32'h0);
        chk("rst_a_evt",   a_evt,        32'h0);
        chk("rst_b_ovf",   32'(b_ovf),   32'h0);
        rst_n = 1'b1;
        tick(2);

        // 1: rising on ch0, latency 3 (dut_a) and 6 (dut_b)
        async_in[0] = 1'b1;
        tick(2);
        chk("t1_pulse_e2", 32'(a_pulse), 32'h0);
        tick(1);
        chk("t1_pulse_e3", 32'(a_pulse), 32'h1);
        chk("t1_level_e3", 32'(a_level), 32'h1);
        tick(1);
        chk("t1_pulse_e4", 32'(a_pulse), 32'h0);
        chk("t1_pend",     32'(a_pend),  32'h1);
        chk("t1_evt",      a_evt,        32'h1);
        tick(1);
        chk("t1_b_pulse_e5", 32'(b_pulse), 32'h0);
        tick(1);
        chk("t1_b_pulse_e6", 32'(b_pulse), 32'h1);
        chk("t1_b_level_e6", 32'(b_level), 32'h1);
        tick(4);
        chk("t1_b_evt", 32'(b_evt), 32'h01);

        // 2: glitch rejection with FILTER_LEN=4
        clr_pc();
        async_in[1] = 1'b1;
        tick(2);
        async_in[1] = 1'b0;
        tick(10);
        chk("t2_glitch_b_pc",    32'(b_pc[1]),    32'd0);
        chk("t2_glitch_b_level", 32'(b_level[1]), 32'd0);
        chk("t2_glitch_a_pc",    32'(a_pc[1]),    32'd1);
        async_in[1] = 1'b1;
        tick(4);
        async_in[1] = 1'b0;
        tick(1);
        chk("t2_b_pulse_e5", 32'(b_pulse[1]), 32'd0);
        tick(1);
        chk("t2_b_pulse_e6", 32'(b_pulse[1]), 32'd1);
        chk("t2_b_level_e6", 32'(b_level[1]), 32'd1);
        tick(10);
        chk("t2_b_level_fall", 32'(b_level[1]), 32'd0);
        chk("t2_b_evt", 32'(b_evt), 32'h05);
        chk("t2_a_evt", a_evt,      32'h00000201);

        // 3: edge modes rising/falling/both/disabled on ch0..ch3
        async_in = '0;
        tick(12);
        edge_mode = 8'b11_10_01_00;
        clr_pc();
        async_in = 4'hF;
        tick(20);
        chk("t3_a_level_hi", 32'(a_level), 32'hF);
        chk("t3_b_level_hi", 32'(b_level), 32'hF);
        async_in = 4'h0;
        tick(20);
        chk("t3_a_level_lo", 32'(a_level), 32'h0);
        chk("t3_b_level_lo", 32'(b_level), 32'h0);
        chk("t3_a_pc0", 32'(a_pc[0]), 32'd1);
        chk("t3_a_pc1", 32'(a_pc[1]), 32'd1);
        chk("t3_a_pc2", 32'(a_pc[2]), 32'd2);
        chk("t3_a_pc3", 32'(a_pc[3]), 32'd0);
        chk("t3_b_pc0", 32'(b_pc[0]), 32'd1);
        chk("t3_b_pc1", 32'(b_pc[1]), 32'd1);
        chk("t3_b_pc2", 32'(b_pc[2]), 32'd2);
        chk("t3_b_pc3", 32'(b_pc[3]), 32'd0);
        chk("t3_a_evt", a_evt,        32'h00020302);
        chk("t3_b_evt", 32'(b_evt),   32'h2A);

        // 4: saturation on dut_b ch2 (CNT_W=2), then clear coincident with a pulse
        edge_mode = '0;
        cnt_clr   = 4'b0100;
        tick(1);
        cnt_clr   = '0;
        chk("t4_clr_cnt", 32'(b_evt[5:4]), 32'd0);
        chk("t4_clr_ovf", 32'(b_ovf[2]),   32'd0);
        for (int e = 0; e < 5; e++) begin
            async_in[2] = 1'b1;
            tick(8);
            async_in[2] = 1'b0;
            tick(8);
            chk($sformatf("t4_cnt_ev%0d", e + 1), 32'(b_evt[5:4]), 32'(exp_cnt[e]));
            chk($sformatf("t4_ovf_ev%0d", e + 1), 32'(b_ovf[2]),   32'(exp_ovf[e]));
        end
        async_in[2] = 1'b1;
        tick(5);
        cnt_clr = 4'b0100;
        tick(1);
        cnt_clr = '0;
        chk("t4_pulse6",   32'(b_pulse[2]),  32'd1);
        chk("t4_cnt_clr6", 32'(b_evt[5:4]),  32'd1);
        chk("t4_ovf_clr6", 32'(b_ovf[2]),    32'd0);
        async_in[2] = 1'b0;
        tick(8);

        // 5: pending handshake on dut_a ch0
        clr_pending = 4'b0001;
        tick(1);
        clr_pending = '0;
        chk("t5_clr", 32'(a_pend[0]), 32'd0);
        clr_pending = 4'b0001;
        tick(1);
        clr_pending = '0;
        chk("t5_clr_idle", 32'(a_pend[0]), 32'd0);
        async_in[0] = 1'b1;
        tick(2);
        clr_pending = 4'b0001;
        tick(1);
        clr_pending = '0;
        chk("t5_coinc_pulse", 32'(a_pulse[0]), 32'd1);
        chk("t5_coinc_pend",  32'(a_pend[0]),  32'd1);
        tick(1);
        chk("t5_pend_hold", 32'(a_pend[0]), 32'd1);
        clr_pending = 4'b0001;
        tick(1);
        clr_pending = '0;
        chk("t5_lone_clr", 32'(a_pend[0]), 32'd0);
        async_in[0] = 1'b0;
        tick(10);

        // 6: input held high through reset, then reset mid-filter
        rst_n       = 1'b0;
        async_in[3] = 1'b1;
        tick(5);
        chk("t6_rst_level", 32'(a_level), 32'h0);
        chk("t6_rst_pend",  32'(a_pend),  32'h0);
        chk("t6_rst_evt",   a_evt,        32'h0);
        chk("t6_rst_b_evt", 32'(b_evt),   32'h0);
        rst_n = 1'b1;
        tick(2);
        chk("t6_pulse_e2", 32'(a_pulse), 32'h0);
        tick(1);
        chk("t6_pulse_e3", 32'(a_pulse), 32'h8);
        chk("t6_level_e3", 32'(a_level), 32'h8);
        tick(1);
        chk("t6_pulse_e4", 32'(a_pulse), 32'h0);
        chk("t6_evt",      a_evt,        32'h01000000);
        tick(2);
        chk("t6_b_pulse_e6", 32'(b_pulse), 32'h8);
        async_in[3] = 1'b0;
        tick(12);
        async_in[1] = 1'b1;
        tick(4);
        chk("t6_midflt_pulse", 32'(b_pulse), 32'h0);
        chk("t6_midflt_level", 32'(b_level[1]), 32'd0);
        rst_n       = 1'b0;
        async_in[1] = 1'b0;
        tick(3);
        rst_n = 1'b1;
        clr_pc();
        tick(12);
        chk("t6_after_b_pc1", 32'(b_pc[1]), 32'd0);
        chk("t6_after_a_pc1", 32'(a_pc[1]), 32'd0);
        chk("t6_after_b_level", 32'(b_level), 32'h0);
        chk("t6_after_b_pend",  32'(b_pend),  32'h0);
        chk("t6_after_b_evt",   32'(b_evt),   32'h0);
        chk("t6_after_b_ovf",   32'(b_ovf),   32'h0);
        chk("t6_after_a_evt",   a_evt,        32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_ch_pulse_sync.md
Name: multi_ch_pulse_sync

Overview:
Multi-channel receive-side synchroniser. It takes NUM_CH asynchronous level/pulse inputs into the fast_clk domain, with a configurable sync depth and glitch filter. Per channel it produces single-cycle edge pulses, a sticky pending flag with clear handshake, and a saturating event counter. It is the parametrised successor to the single-channel slow-to-fast pulse synchroniser and serves as the common event-import block for status/interrupt sources from foreign clock domains.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, flops in each synchroniser chain (>=2)
FILTER_LEN, 1, consecutive fast_clk cycles a new synced level must hold before acceptance (>=1; 1 = no filtering)
CNT_W, 8, width of each per-channel event counter (>=1)

Ports:
fast_clk  input  1  single clock; every register in the block is clocked on its rising edge
rst_n  input  1  reset, synchronous, active-low
async_in  input  NUM_CH  asynchronous inputs, one bit per channel
edge_mode  input  2*NUM_CH  per channel, bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled; synchronous to fast_clk
pulse_fast_out  output  NUM_CH  one-cycle event pulse per channel
level_out  output  NUM_CH  filtered synchronised level per channel
pending  output  NUM_CH  sticky event flag per channel
clr_pending  input  NUM_CH  one-cycle clear of pending, per channel
evt_cnt  output  NUM_CH*CNT_W  event counters; channel i at [CNT_W*i +: CNT_W]
cnt_clr  input  NUM_CH  per-channel clear of evt_cnt and cnt_ovf
cnt_ovf  output  NUM_CH  sticky counter-saturation flag per channel

Behaviour:
- Reset: rst_n low at a rising edge of fast_clk clears the following to 0:
  - all sync flops and filter counters;
  - level_out, pulse_fast_out, pending, evt_cnt, cnt_ovf.
- Reset mid-operation discards in-flight edges. An input held high through reset is seen as a 0->1 transition after release and produces a rising event.
- Sync chain: SYNC_STAGES flops per channel. Only the first flop samples async_in. No logic between stages.
- Filter, per channel:
  - flt_cnt ranges 0..FILTER_LEN-1.
  - If sync_out == level_out: flt_cnt <= 0.
  - Else if flt_cnt == FILTER_LEN-1: level_out <= sync_out and flt_cnt <= 0 (acceptance).
  - Else: flt_cnt <= flt_cnt+1.
  - Excursions shorter than FILTER_LEN synced cycles are rejected: no level_out change and no pulse.
- Edge detect: pulse_fast_out[i] is registered. It is asserted for exactly one cycle, on the same edge as an acceptance whose direction matches edge_mode:
  - rising = new level 1;
  - falling = new level 0;
  - both = any acceptance;
  - disabled = never.
  - level_out tracks in all modes.
- Latency: count the rising edge at which the first sync flop captures a stable new value as edge 1. level_out and pulse_fast_out update at edge SYNC_STAGES+FILTER_LEN.
- Minimum resolvable spacing: two changes separated by at least FILTER_LEN+1 fast_clk cycles each produce an event.
- edge_mode is sampled at acceptance time. A mode change alone never produces a pulse.
- pending[i]:
  - set on the edge pulse_fast_out[i] is set;
  - cleared by clr_pending[i];
  - set wins if both occur on the same edge;
  - clr on an already-clear flag has no effect.
- evt_cnt[i]:
  - +1 on each pulse;
  - saturates at 2^CNT_W-1;
  - a pulse arriving while at max leaves the count unchanged and sets cnt_ovf[i].
- cnt_clr[i] zeroes evt_cnt[i] and cnt_ovf[i]. If cnt_clr and a pulse coincide, the result is evt_cnt=1 and cnt_ovf=0.
- Channels are fully independent. No shared state and no cross-channel priority.
- All outputs are registered, so the block has no combinational input-to-output paths.

Test Plan:
1. Defaults, ch0 mode 00: after reset, async_in[0] 0->1 held 10 cycles -> level_out[0]=1 and pulse_fast_out[0] high for one cycle at edge 3 (SYNC_STAGES+FILTER_LEN=3); pending[0]=1; evt_cnt ch0=1; other channels quiet.
2. FILTER_LEN=4: a 2-cycle high glitch on async_in[1] gives no pulse and level_out[1] stays 0. A 4-cycle high gives one pulse at edge 6 relative to capture.
3. Modes on ch0..ch3 = 00/01/10/11: drive one 0->1->0 square (20 cycles each level) on all channels. Required pulse counts: ch0=1, ch1=1, ch2=2, ch3=0; level_out follows on all four.
4. CNT_W=2: 5 rising events on ch2 -> evt_cnt ch2=3 and cnt_ovf[2]=1 after the 4th event. Asserting cnt_clr[2] on the same edge as a 6th pulse -> evt_cnt=1, cnt_ovf=0.
5. Pending handshake: clr_pending[0] coincident with a new pulse -> pending[0] stays 1. A later lone clr_pending[0] -> 0 next cycle.
6. async_in[3] held high with rst_n low for 5 cycles, then rst_n high -> one rising pulse at edge 3 after release. Asserting rst_n low mid-filter (FILTER_LEN=4, count=2) -> no pulse and all outputs 0.
